// File: rtl/double_gt_arbiter_if.sv
// rtl/double_gt_arbiter_if.sv - requester, comparator and result signals of the shared double greater-than arbiter
interface double_gt_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [64*NUM_REQ-1:0] req_a;
  logic [64*NUM_REQ-1:0] req_b;
  logic [63:0]           cmp_a;
  logic [63:0]           cmp_b;
  logic                  cmp_z;
  logic [NUM_REQ-1:0]    res_valid;
  logic                  res_z;
  logic [3:0]            inflight;

  modport slave (
    input  req_valid, req_a, req_b, cmp_z,
    output req_ready, cmp_a, cmp_b, res_valid, res_z, inflight
  );

  modport master (
    output req_valid, req_a, req_b, cmp_z,
    input  req_ready, cmp_a, cmp_b, res_valid, res_z, inflight
  );
endinterface

// File: rtl/double_gt_arbiter.sv
// rtl/double_gt_arbiter.sv - round-robin front end sharing one pipelined double greater-than comparator
module double_gt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  double_gt_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t               ptr;
  idx_t               grant_idx;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  int                 cand;
  logic [LATENCY:0]   tag_valid;
  idx_t               tag_idx [LATENCY+1];
  logic               emit;

  // Rotating priority search starting at ptr; first valid requester wins.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && bus.req_valid[idx_t'(cand)]) begin
        found     = 1'b1;
        grant_idx = idx_t'(cand);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign emit          = tag_valid[LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      bus.cmp_a     <= '0;
      bus.cmp_b     <= '0;
      bus.res_valid <= '0;
      bus.res_z     <= 1'b0;
      bus.inflight  <= '0;
      tag_valid     <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      // Tag stage LATENCY lines up with the comparator output for the same operands.
      tag_valid  <= {tag_valid[LATENCY-1:0], found};
      tag_idx[0] <= grant_idx;
      for (int i = 1; i <= LATENCY; i++) tag_idx[i] <= tag_idx[i-1];

      if (found) begin
        bus.cmp_a <= bus.req_a[64*grant_idx +: 64];
        bus.cmp_b <= bus.req_b[64*grant_idx +: 64];
        ptr       <= (grant_idx == idx_t'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end

      bus.res_valid <= '0;
      if (emit) begin
        bus.res_valid[tag_idx[LATENCY]] <= 1'b1;
        bus.res_z                       <= bus.cmp_z;
      end

      bus.inflight <= bus.inflight + 4'(found) - 4'(emit);
    end
  end
endmodule

// File: tb/tb_double_gt_arbiter.sv
// tb/tb_double_gt_arbiter.sv - randomized and directed bench for double_gt_arbiter against a due-time queue model
module tb_double_gt_arbiter;
  localparam int N = 4;
  localparam int L = 3;
  localparam logic [63:0] D0  = 64'h0000000000000000;
  localparam logic [63:0] DN0 = 64'h8000000000000000;
  localparam logic [63:0] D1  = 64'h3FF0000000000000;
  localparam logic [63:0] D2  = 64'h4000000000000000;
  localparam logic [63:0] D3  = 64'h4008000000000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  double_gt_arbiter_if #(.NUM_REQ(N)) bus ();
  double_gt_arbiter #(.NUM_REQ(N), .LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic bit gt(input logic [63:0] a, input logic [63:0] b);
    return $bitstoreal(a) > $bitstoreal(b);
  endfunction

  // External comparator: result reflects operands L edges after they change.
  logic [L-1:0] zpipe;
  always @(posedge clk) zpipe <= {zpipe[L-2:0], gt(bus.cmp_a, bus.cmp_b)};
  assign bus.cmp_z = zpipe[L-1];

  typedef struct {
    int     idx;
    bit     z;
    longint due;
  } exp_t;

  exp_t        q[$];
  longint      cyc = 0;
  int          m_ptr = 0;
  logic [63:0] m_cmp_a = '0;
  logic [63:0] m_cmp_b = '0;
  bit          m_res_z = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  logic [N-1:0] exp_ready, obs_ready, exp_rv, obs_rv;
  logic         exp_z, obs_z;
  logic [3:0]   exp_inf, obs_inf;
  logic [127:0] exp_cmp, obs_cmp;

  task automatic model_clear();
    q.delete();
    m_ptr   = 0;
    m_cmp_a = '0;
    m_cmp_b = '0;
    m_res_z = 1'b0;
  endtask

  // Drives one cycle of requests, advances one edge and records model vs DUT values.
  task automatic cycle(input logic [N-1:0] v, input logic [64*N-1:0] a, input logic [64*N-1:0] b);
    int   g;
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = v;
    bus.req_a = a;
    bus.req_b = b;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (g < 0 && v[j]) g = j;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = bus.req_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      e.idx = g;
      e.z   = gt(a[g*64 +: 64], b[g*64 +: 64]);
      e.due = cyc + L + 1;
      q.push_back(e);
      m_cmp_a = a[g*64 +: 64];
      m_cmp_b = b[g*64 +: 64];
      m_ptr   = (g + 1) % N;
    end
    exp_rv = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv[q[0].idx] = 1'b1;
      m_res_z = q[0].z;
      void'(q.pop_front());
    end
    exp_z   = m_res_z;
    exp_inf = 4'(q.size());
    exp_cmp = {m_cmp_a, m_cmp_b};
    obs_rv  = bus.res_valid;
    obs_z   = bus.res_z;
    obs_inf = bus.inflight;
    obs_cmp = {bus.cmp_a, bus.cmp_b};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    @(posedge clk);
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL reset ready: got %b want 0001", bus.req_ready); end
    n_vec++; if (bus.res_valid !== 4'b0000) begin n_err++; $display("FAIL reset res_valid: got %b want 0000", bus.res_valid); end
    n_vec++; if (bus.res_z !== 1'b0) begin n_err++; $display("FAIL reset res_z: got %b want 0", bus.res_z); end
    n_vec++; if (bus.inflight !== 4'd0) begin n_err++; $display("FAIL reset inflight: got %0d want 0", bus.inflight); end
    n_vec++; if ({bus.cmp_a, bus.cmp_b} !== 128'h0) begin n_err++; $display("FAIL reset cmp: got %h want 0", {bus.cmp_a, bus.cmp_b}); end
    bus.req_valid = '0;
    model_clear();
  endtask

  task automatic test_all_four();
    logic [64*N-1:0] a, b;
    a = {D3, D2, D1, D0};
    b = {D2, D2, D2, D2};
    for (int i = 0; i < 14; i++) begin
      cycle((i < 8) ? 4'b1111 : 4'b0000, a, b);
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL all4 ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL all4 res_valid c%0d: got %b want %b", i, obs_rv, exp_rv); end
      n_vec++; if (obs_z !== exp_z) begin n_err++; $display("FAIL all4 res_z c%0d: got %b want %b", i, obs_z, exp_z); end
      n_vec++; if (obs_inf !== exp_inf) begin n_err++; $display("FAIL all4 inflight c%0d: got %0d want %0d", i, obs_inf, exp_inf); end
    end
  endtask

  task automatic test_single();
    logic [64*N-1:0] a, b;
    a = {D0, D0, D0, D2};
    b = {D0, D0, D0, D1};
    for (int i = 0; i < 6; i++) begin
      cycle((i == 0) ? 4'b0001 : 4'b0000, a, b);
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL single ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL single res_valid c%0d: got %b want %b", i, obs_rv, exp_rv); end
      n_vec++; if (obs_inf !== exp_inf) begin n_err++; $display("FAIL single inflight c%0d: got %0d want %0d", i, obs_inf, exp_inf); end
      n_vec++; if (obs_cmp !== exp_cmp) begin n_err++; $display("FAIL single cmp c%0d: got %h want %h", i, obs_cmp, exp_cmp); end
      if (i == 4) begin
        n_vec++; if (obs_rv !== 4'b0001 || obs_z !== 1'b1) begin n_err++; $display("FAIL single result: got rv=%b z=%b want rv=0001 z=1", obs_rv, obs_z); end
      end
    end
  endtask

  task automatic test_rotation();
    logic [64*N-1:0] a, b;
    logic [N-1:0]    v;
    a = {D3, D1, D2, D0};
    b = {D1, D2, D1, D3};
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 4'b0100 : (i == 3 || i == 4) ? 4'b1111 : 4'b0000;
      cycle(v, a, b);
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rotate ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      n_vec++; if (obs_rv !== exp_rv || obs_z !== exp_z) begin n_err++; $display("FAIL rotate result c%0d: got %b/%b want %b/%b", i, obs_rv, obs_z, exp_rv, exp_z); end
      if (i == 3) begin
        n_vec++; if (obs_ready !== 4'b1000) begin n_err++; $display("FAIL rotate first: got %b want 1000", obs_ready); end
      end
      if (i == 4) begin
        n_vec++; if (obs_ready !== 4'b0001) begin n_err++; $display("FAIL rotate second: got %b want 0001", obs_ready); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [64*N-1:0] a, b;
    logic [63:0]     pa [3];
    logic [63:0]     pb [3];
    pa[0] = D1;  pb[0] = D2;
    pa[1] = D2;  pb[1] = D1;
    pa[2] = DN0; pb[2] = D0;
    for (int i = 0; i < 8; i++) begin
      a = {D3, D3, D3, D3};
      b = {D0, D0, D0, D0};
      if (i < 3) begin
        a[64 +: 64] = pa[i];
        b[64 +: 64] = pb[i];
      end
      cycle((i < 3) ? 4'b0010 : 4'b0000, a, b);
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL b2b ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL b2b res_valid c%0d: got %b want %b", i, obs_rv, exp_rv); end
      n_vec++; if (obs_z !== exp_z) begin n_err++; $display("FAIL b2b res_z c%0d: got %b want %b", i, obs_z, exp_z); end
      n_vec++; if (obs_cmp !== exp_cmp) begin n_err++; $display("FAIL b2b cmp c%0d: got %h want %h", i, obs_cmp, exp_cmp); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [64*N-1:0] a, b;
    a = {D2, D3, D1, D2};
    b = {D1, D1, D2, D3};
    for (int i = 0; i < 5; i++) begin
      cycle((i < 3) ? 4'b1111 : 4'b0000, a, b);
      n_vec++; if (obs_rv !== exp_rv || obs_z !== exp_z) begin n_err++; $display("FAIL midrst pre c%0d: got %b/%b want %b/%b", i, obs_rv, obs_z, exp_rv, exp_z); end
      n_vec++; if (obs_inf !== exp_inf) begin n_err++; $display("FAIL midrst pre inflight c%0d: got %0d want %0d", i, obs_inf, exp_inf); end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    n_vec++; if (bus.res_valid !== 4'b0000) begin n_err++; $display("FAIL midrst res_valid: got %b want 0000", bus.res_valid); end
    n_vec++; if (bus.inflight !== 4'd0) begin n_err++; $display("FAIL midrst inflight: got %0d want 0", bus.inflight); end
    n_vec++; if ({bus.cmp_a, bus.cmp_b} !== 128'h0) begin n_err++; $display("FAIL midrst cmp: got %h want 0", {bus.cmp_a, bus.cmp_b}); end
    model_clear();
    for (int i = 0; i < 7; i++) begin
      cycle((i == 0) ? 4'b1111 : 4'b0000, a, b);
      if (i == 0) begin
        n_vec++; if (obs_ready !== 4'b0001) begin n_err++; $display("FAIL midrst ptr: got %b want 0001", obs_ready); end
      end
      n_vec++; if (obs_rv !== exp_rv || obs_z !== exp_z) begin n_err++; $display("FAIL midrst post c%0d: got %b/%b want %b/%b", i, obs_rv, obs_z, exp_rv, exp_z); end
      n_vec++; if (obs_inf !== exp_inf) begin n_err++; $display("FAIL midrst post inflight c%0d: got %0d want %0d", i, obs_inf, exp_inf); end
    end
  endtask

  task automatic test_idle();
    logic [64*N-1:0] a, b;
    a = {D1, D2, D3, D1};
    b = {D3, D3, D3, D3};
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000, a, b);
      n_vec++; if (obs_ready !== 4'b0000 || obs_rv !== 4'b0000) begin n_err++; $display("FAIL idle c%0d: got ready=%b rv=%b want 0000", i, obs_ready, obs_rv); end
      n_vec++; if (obs_cmp !== exp_cmp) begin n_err++; $display("FAIL idle cmp c%0d: got %h want %h", i, obs_cmp, exp_cmp); end
    end
  endtask

  task automatic test_random();
    logic [64*N-1:0] a, b;
    logic [N-1:0]    v;
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < N; k++) begin
        a[64*k +: 64] = {$urandom, $urandom};
        b[64*k +: 64] = ($urandom_range(0, 3) == 0) ? a[64*k +: 64] : {$urandom, $urandom};
      end
      v = (i < 190) ? N'($urandom_range(0, 15)) : '0;
      cycle(v, a, b);
      n_vec++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rand ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      n_vec++; if (obs_rv !== exp_rv) begin n_err++; $display("FAIL rand res_valid c%0d: got %b want %b", i, obs_rv, exp_rv); end
      n_vec++; if (obs_z !== exp_z) begin n_err++; $display("FAIL rand res_z c%0d: got %b want %b", i, obs_z, exp_z); end
      n_vec++; if (obs_inf !== exp_inf) begin n_err++; $display("FAIL rand inflight c%0d: got %0d want %0d", i, obs_inf, exp_inf); end
      n_vec++; if (obs_cmp !== exp_cmp) begin n_err++; $display("FAIL rand cmp c%0d: got %h want %h", i, obs_cmp, exp_cmp); end
    end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_rotation();
    test_back_to_back();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
